// File: rtl/alu_sram_pipe_pkg.sv
// Shared types for the ALU + bit-maskable SRAM pipeline: opcode encoding and status flags.
package alu_sram_pkg;

  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_READ  = 3'd5,
    ALU_WRITE = 3'd6,
    ALU_RSVD  = 3'd7
  } op_e;

  // Bit order matches the {zero, carry, negative, overflow} status port.
  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_sram_pipe_if.sv
// Command (valid/ready) and response (valid/yumi) bundle for alu_sram_pipe.
interface alu_sram_pipe_if
  import alu_sram_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 512
);
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic                     v_i;
  logic                     ready_o;
  logic [OP_WIDTH-1:0]      op_i;
  logic [width_p-1:0]       a_i;
  logic [width_p-1:0]       b_i;
  logic [addr_width_lp-1:0] addr_i;
  logic [width_p-1:0]       wmask_i;
  logic                     v_o;
  logic                     yumi_i;
  logic [width_p-1:0]       data_o;
  logic                     err_o;

  modport master (
    output v_i, op_i, a_i, b_i, addr_i, wmask_i, yumi_i,
    input  ready_o, v_o, data_o, err_o
  );

  modport slave (
    input  v_i, op_i, a_i, b_i, addr_i, wmask_i, yumi_i,
    output ready_o, v_o, data_o, err_o
  );

endinterface

// File: rtl/alu_sram_pipe_alu_core.sv
// Combinational ALU for alu_sram_pipe; WRITE passes operand A through as the store value.
// Raw status flags are built only when ALU_SRAM_PIPE_FLAGS_EN is defined.
module alu_core
  import alu_sram_pkg::*;
#(
  parameter int width_p = 8
) (
  input  op_e                op,
  input  logic [width_p-1:0] a,
  input  logic [width_p-1:0] b,
  output logic [width_p-1:0] res
`ifdef ALU_SRAM_PIPE_FLAGS_EN
  , output flags_t           flags
`endif
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    res = '0;
    case (op)
      ALU_ADD:   res = a + b;
      ALU_SUB:   res = a - b;
      ALU_AND:   res = a & b;
      ALU_OR:    res = a | b;
      ALU_XOR:   res = a ^ b;
      ALU_WRITE: res = a;
      default:   res = '0;
    endcase
  end

`ifdef ALU_SRAM_PIPE_FLAGS_EN
  // Carry out of a wrapped add shows up as a result smaller than an operand; borrow is a < b.
  always_comb begin
    flags      = '0;
    flags.zero = (res == '0);
    flags.neg  = res[width_p-1];
    case (op)
      ALU_ADD: begin
        flags.carry = (res < a);
        flags.ovf   = (a[width_p-1] == b[width_p-1]) && (res[width_p-1] != a[width_p-1]);
      end
      ALU_SUB: begin
        flags.carry = (a < b);
        flags.ovf   = (a[width_p-1] != b[width_p-1]) && (res[width_p-1] != a[width_p-1]);
      end
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/alu_sram_pipe.sv
// ALU + width_p x els_p bit-maskable memory, one response per command, full throughput.
// Defining ALU_SRAM_PIPE_FLAGS_EN adds the registered flags_o status port.
module alu_sram_pipe
  import alu_sram_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 512
) (
  input  logic           clk_i,
  input  logic           reset_i,
  alu_sram_pipe_if.slave bus
`ifdef ALU_SRAM_PIPE_FLAGS_EN
  , output logic [3:0]   flags_o
`endif
);

  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [addr_width_lp:0] els_lp = (addr_width_lp + 1)'(els_p);

  logic [width_p-1:0] mem [els_p];
  logic               v_r, err_r;
  logic [width_p-1:0] data_r, res;
  op_e                op;
  logic               accept, cmd_err, mem_we;

  assign op      = op_e'(bus.op_i);
  assign accept  = bus.v_i & bus.ready_o;
  // Out-of-range addresses must never touch the array, whatever the opcode.
  assign cmd_err = (op == ALU_RSVD) | ({1'b0, bus.addr_i} >= els_lp);
  assign mem_we  = accept & ~cmd_err & (op != ALU_READ);

  assign bus.ready_o = ~reset_i & (~v_r | bus.yumi_i);
  assign bus.v_o     = v_r;
  assign bus.data_o  = data_r;
  assign bus.err_o   = err_r;

`ifdef ALU_SRAM_PIPE_FLAGS_EN
  flags_t core_flags;
`endif

  alu_core #(.width_p(width_p)) u_alu (
    .op    (op),
    .a     (bus.a_i),
    .b     (bus.b_i),
    .res   (res)
`ifdef ALU_SRAM_PIPE_FLAGS_EN
    , .flags (core_flags)
`endif
  );

  // NOTE: the storage array has no reset; clearing it would defeat RAM inference.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < width_p; i++) begin
        if (bus.wmask_i[i]) mem[bus.addr_i][i] <= res[i];
      end
    end
  end

  // Response register doubles as the read port: it only reloads on an accept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      v_r    <= 1'b0;
      data_r <= '0;
      err_r  <= 1'b0;
    end else if (accept) begin
      v_r   <= 1'b1;
      err_r <= cmd_err;
      if (cmd_err)              data_r <= '0;
      else if (op == ALU_READ)  data_r <= mem[bus.addr_i];
      else                      data_r <= res;
    end else if (bus.yumi_i) begin
      v_r <= 1'b0;
    end
  end

`ifdef ALU_SRAM_PIPE_FLAGS_EN
  flags_t flags_r;
  logic   rd_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flags_r <= '0;
      rd_r    <= 1'b0;
    end else if (accept) begin
      rd_r    <= ~cmd_err & (op == ALU_READ);
      flags_r <= cmd_err ? flags_t'(4'b1000) : core_flags;
    end
  end

  // Read data only exists after the edge, so its flags are derived from the held response.
  assign flags_o = rd_r ? {data_r == '0, 1'b0, data_r[width_p-1], 1'b0} : flags_r;
`endif

endmodule

// File: tb/tb_alu_sram_pipe.sv
// Self-checking bench for alu_sram_pipe: directed cases with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_alu_sram_pipe;
  import alu_sram_pkg::*;

  localparam int W   = 8;
  localparam int ELS = 512;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_sram_pipe_if #(.width_p(W), .els_p(ELS)) bus ();
  alu_sram_pipe_if #(.width_p(W), .els_p(300)) bus3 ();

`ifdef ALU_SRAM_PIPE_FLAGS_EN
  logic [3:0] flags, flags3;
`endif

  alu_sram_pipe #(.width_p(W), .els_p(ELS)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
`ifdef ALU_SRAM_PIPE_FLAGS_EN
    , .flags_o (flags)
`endif
  );

  alu_sram_pipe #(.width_p(W), .els_p(300)) dut300 (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus3)
`ifdef ALU_SRAM_PIPE_FLAGS_EN
    , .flags_o (flags3)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain word array plus the single pending response.
  logic [W-1:0] mmem [ELS];
  logic         exp_v = 1'b0;
  logic [W-1:0] exp_d = '0;
  logic         exp_e = 1'b0;
  logic         m_ready;
  logic [2:0]   m_op;
  logic [W-1:0] m_r;

  always @(posedge clk) begin
    m_ready = !reset && (!exp_v || bus.yumi_i);
    if (reset) begin
      exp_v = 1'b0; exp_d = '0; exp_e = 1'b0;
    end else if (bus.v_i && m_ready) begin
      m_op = bus.op_i;
      if (m_op == 3'd7 || int'(bus.addr_i) >= ELS) begin
        exp_d = '0; exp_e = 1'b1;
      end else begin
        case (m_op)
          3'd0:    m_r = bus.a_i + bus.b_i;
          3'd1:    m_r = bus.a_i - bus.b_i;
          3'd2:    m_r = bus.a_i & bus.b_i;
          3'd3:    m_r = bus.a_i | bus.b_i;
          3'd4:    m_r = bus.a_i ^ bus.b_i;
          3'd6:    m_r = bus.a_i;
          default: m_r = mmem[bus.addr_i];
        endcase
        if (m_op != 3'd5)
          mmem[bus.addr_i] = (mmem[bus.addr_i] & ~bus.wmask_i) | (m_r & bus.wmask_i);
        exp_d = m_r; exp_e = 1'b0;
      end
      exp_v = 1'b1;
    end else if (bus.yumi_i) begin
      exp_v = 1'b0;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    check("ready", bus.ready_o, !reset && (!exp_v || bus.yumi_i));
    check("v_o", bus.v_o, exp_v);
    if (exp_v) begin
      check("data", bus.data_o, exp_d);
      check("err", bus.err_o, exp_e);
    end
  end

  task automatic drive(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [8:0] addr, input logic [W-1:0] m);
    bus.v_i = 1'b1; bus.op_i = op; bus.a_i = a; bus.b_i = b;
    bus.addr_i = addr; bus.wmask_i = m; bus.yumi_i = exp_v;
    @(posedge clk); #1;
    bus.v_i = 1'b0; bus.yumi_i = 1'b1;
    #1;
  endtask

  task automatic resp(input string n, input logic [W-1:0] d, input logic e);
    check({n, "_v"}, bus.v_o, 1'b1);
    check(n, bus.data_o, d);
    check({n, "_err"}, bus.err_o, e);
  endtask

  initial begin
    bus.v_i = 0; bus.op_i = 0; bus.a_i = 0; bus.b_i = 0; bus.addr_i = 0; bus.wmask_i = 0; bus.yumi_i = 0;
    bus3.v_i = 0; bus3.op_i = 0; bus3.a_i = 0; bus3.b_i = 0; bus3.addr_i = 0; bus3.wmask_i = 0; bus3.yumi_i = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_v", bus.v_o, 1'b0);
    check("rst_data", bus.data_o, 8'h00);
    check("rst_err", bus.err_o, 1'b0);
    check("rst_ready", bus.ready_o, 1'b1);

    drive(ALU_ADD, 8'h01, 8'h03, 9'd0, 8'hFF);   resp("add", 8'h04, 1'b0);
    drive(ALU_READ, 8'h00, 8'h00, 9'd0, 8'hFF);  resp("rd0", 8'h04, 1'b0);
    drive(ALU_WRITE, 8'hA0, 8'h00, 9'd5, 8'hFF); resp("wr5", 8'hA0, 1'b0);
    drive(ALU_SUB, 8'h01, 8'h03, 9'd5, 8'h0F);   resp("sub", 8'hFE, 1'b0);
    drive(ALU_READ, 8'h00, 8'h00, 9'd5, 8'hFF);  resp("rd5", 8'hAE, 1'b0);

    drive(ALU_WRITE, 8'h5A, 8'h00, 9'd511, 8'hFF); resp("wr511", 8'h5A, 1'b0);
    check("b2b_ready", bus.ready_o, 1'b1);
    drive(ALU_READ, 8'h00, 8'h00, 9'd511, 8'hFF);  resp("rd511", 8'h5A, 1'b0);
    check("b2b_ready2", bus.ready_o, 1'b1);

    drive(ALU_WRITE, 8'hC3, 8'h00, 9'd20, 8'hFF); resp("wr20", 8'hC3, 1'b0);
    bus.yumi_i = 1'b0; bus.v_i = 1'b1; bus.op_i = ALU_WRITE;
    bus.a_i = 8'h3C; bus.addr_i = 9'd21; bus.wmask_i = 8'hFF;
    #1 check("bp_ready0", bus.ready_o, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_ready", bus.ready_o, 1'b0);
      resp("bp_hold", 8'hC3, 1'b0);
    end
    bus.yumi_i = 1'b1;
    #1 check("bp_release", bus.ready_o, 1'b1);
    @(posedge clk); #1;
    bus.v_i = 1'b0;
    #1 resp("bp_new", 8'h3C, 1'b0);
    drive(ALU_READ, 8'h00, 8'h00, 9'd20, 8'hFF); resp("rd20", 8'hC3, 1'b0);
    drive(ALU_READ, 8'h00, 8'h00, 9'd21, 8'hFF); resp("rd21", 8'h3C, 1'b0);

    drive(ALU_RSVD, 8'h55, 8'h66, 9'd0, 8'hFF);  resp("rsvd", 8'h00, 1'b1);
    drive(ALU_READ, 8'h00, 8'h00, 9'd0, 8'hFF);  resp("rd0_after", 8'h04, 1'b0);
    drive(ALU_WRITE, 8'h00, 8'h00, 9'd0, 8'h00); resp("wr_nomask", 8'h00, 1'b0);
    drive(ALU_READ, 8'h00, 8'h00, 9'd0, 8'hFF);  resp("rd0_nomask", 8'h04, 1'b0);

    // Shallow instance: addresses at or above 300 are errors.
    bus3.v_i = 1; bus3.op_i = ALU_WRITE; bus3.a_i = 8'h33; bus3.addr_i = 9'd299; bus3.wmask_i = 8'hFF;
    @(posedge clk); #1;
    check("s_wr_v", bus3.v_o, 1'b1); check("s_wr", bus3.data_o, 8'h33); check("s_wr_err", bus3.err_o, 1'b0);
    bus3.yumi_i = 1; bus3.a_i = 8'h77; bus3.addr_i = 9'd300;
    @(posedge clk); #1;
    check("s_oor", bus3.data_o, 8'h00); check("s_oor_err", bus3.err_o, 1'b1);
    bus3.op_i = ALU_ADD; bus3.a_i = 8'h01; bus3.b_i = 8'h01; bus3.addr_i = 9'd400;
    @(posedge clk); #1;
    check("s_oor_add", bus3.data_o, 8'h00); check("s_oor_add_err", bus3.err_o, 1'b1);
    bus3.op_i = ALU_READ; bus3.addr_i = 9'd299;
    @(posedge clk); #1;
    check("s_rd299", bus3.data_o, 8'h33); check("s_rd299_err", bus3.err_o, 1'b0);
    bus3.v_i = 0;
    @(posedge clk); #1;
    bus3.yumi_i = 0;
    check("s_idle_v", bus3.v_o, 1'b0);

    // Reset while a response is pending and a command is offered.
    drive(ALU_WRITE, 8'h11, 8'h00, 9'd7, 8'hFF); resp("wr7", 8'h11, 1'b0);
    bus.yumi_i = 1'b0; bus.v_i = 1'b1; bus.op_i = ALU_WRITE; bus.a_i = 8'h22;
    bus.addr_i = 9'd7; bus.wmask_i = 8'hFF;
    reset = 1'b1;
    #1 check("rst_ready_busy", bus.ready_o, 1'b0);
    @(posedge clk); #1;
    check("rst2_v", bus.v_o, 1'b0);
    check("rst2_data", bus.data_o, 8'h00);
    check("rst2_err", bus.err_o, 1'b0);
    bus.v_i = 1'b0; reset = 1'b0;
    #1;
    drive(ALU_READ, 8'h00, 8'h00, 9'd7, 8'hFF); resp("rd7", 8'h11, 1'b0);

`ifdef ALU_SRAM_PIPE_FLAGS_EN
    drive(ALU_ADD, 8'h80, 8'h80, 9'd8, 8'hFF); resp("add80", 8'h00, 1'b0);
    check("flags_add80", flags, 4'b1101);
    drive(ALU_READ, 8'h00, 8'h00, 9'd8, 8'hFF); resp("rd8", 8'h00, 1'b0);
    check("flags_rd8", flags, 4'b1000);
`endif

    // Prefill so every randomized READ has a defined expectation.
    for (int i = 0; i < ELS; i++) drive(ALU_WRITE, 8'($urandom), 8'h00, 9'(i), 8'hFF);

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      bus.v_i     = ($urandom_range(0, 3) != 0);
      bus.op_i    = 3'($urandom_range(0, 7));
      bus.a_i     = 8'($urandom);
      bus.b_i     = 8'($urandom);
      bus.addr_i  = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, ELS - 1));
      case ($urandom_range(0, 3))
        0:       bus.wmask_i = 8'hFF;
        1:       bus.wmask_i = 8'h00;
        default: bus.wmask_i = 8'($urandom);
      endcase
      bus.yumi_i  = exp_v && ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.v_i = 1'b0; bus.yumi_i = exp_v;
    @(posedge clk); #1;
    bus.yumi_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
